// File: rtl/hdc_pkg.sv
// hdc_pkg: shared sizes, hypervector constants, label and FSM encodings and the
// rotate helper for the HDC ham/spam classifier.
package hdc_pkg;

   localparam int unsigned D         = 1024;
   localparam int unsigned CHUNK     = 64;
   localparam int unsigned MSG_CHARS = 200;
   localparam int unsigned NCHUNKS   = D / CHUNK;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned DIST_W    = $clog2(D) + 1;
   localparam int unsigned PC_W      = $clog2(CHUNK + 1);

   localparam logic [1:0] LBL_HAM  = 2'b00;
   localparam logic [1:0] LBL_SPAM = 2'b01;
   localparam logic [1:0] LBL_NONE = 2'b11;

   typedef logic [2:0] state_t;
   localparam state_t S_IDLE    = 3'd0;
   localparam state_t S_LOAD    = 3'd1;
   localparam state_t S_ENCODE  = 3'd2;
   localparam state_t S_THRESH  = 3'd3;
   localparam state_t S_COMPARE = 3'd4;
   localparam state_t S_DONE    = 3'd5;

   // Deterministic xorshift32 fill, used only to build the constant hypervectors
   function automatic logic [D-1:0] gen_hv(input logic [31:0] seed);
      logic [D-1:0] v;
      logic [31:0]  x;
      v = '0;
      x = seed;
      for (int k = 0; k < int'(D / 32); k++) begin
         x = x ^ (x << 13);
         x = x ^ (x >> 17);
         x = x ^ (x << 5);
         v[k*32 +: 32] = x;
      end
      return v;
   endfunction

   // Rotate left by s bit positions (modulo D)
   function automatic logic [D-1:0] rotl(input logic [D-1:0] v, input int unsigned s);
      logic [2*D-1:0] t;
      t = {v, v} << (s % D);
      return t[2*D-1 -: D];
   endfunction

   localparam logic [D-1:0] BASE_HV = gen_hv(32'h2545_F491);
   localparam logic [D-1:0] HAM_HV  = gen_hv(32'h1F2E_3D4C);
   localparam logic [D-1:0] SPAM_HV = gen_hv(32'h9A8B_7C6D);

endpackage

// File: rtl/hdc_popcount.sv
// hdc_popcount: combinational population count of a W-bit slice.
module hdc_popcount
   import hdc_pkg::*;
#(
   parameter int unsigned W = CHUNK
) (
   input  logic [W-1:0]             vec,
   output logic [$clog2(W+1)-1:0]   count_c
);

   localparam int unsigned CW = $clog2(W + 1);

   // Sum of set bits
   always_comb begin
      count_c = '0;
      for (int k = 0; k < int'(W); k++) begin
         count_c = count_c + CW'(vec[k]);
      end
   end

endmodule

// File: rtl/hdc_main.sv
// hdc_main: HDC ham/spam text classifier. Trigram encoding, majority bundling,
// chunked Hamming comparison against two class hypervectors.
// Optional macro HDC_TIE_HAM_EN: equal distances report ham instead of inconclusive.
module hdc_main
   import hdc_pkg::*;
#(
   parameter logic [D-1:0] HAM_CLASS  = HAM_HV,
   parameter logic [D-1:0] SPAM_CLASS = SPAM_HV
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [8*MSG_CHARS-1:0] msg,
   input  logic [7:0]             length,
   input  logic [1:0]             label,
   output logic [1:0]             result
);

   localparam int unsigned MSG_W      = 8 * MSG_CHARS;
   localparam logic [7:0]  CAP        = 8'(MSG_CHARS);
   localparam logic [7:0]  LAST_CHUNK = 8'(NCHUNKS - 1);

   state_t             state_q;
   state_t             state_d;
   logic [MSG_W-1:0]   msg_q;
   logic [MSG_W-1:0]   msg_w;
   logic [7:0]         len_q;
   logic [7:0]         len_c;
   logic [7:0]         len_w;
   logic [7:0]         n_w;
   logic [7:0]         idx;
   logic               start_q;
   logic               n_ok;
   logic               change_c;
   logic               restart_c;
   logic [CNT_W-1:0]   cnt [D];
   logic [D-1:0]       tri_c;
   logic [D-1:0]       query_c;
   logic [D-1:0]       diff_h;
   logic [D-1:0]       diff_s;
   logic [PC_W-1:0]    pc_h;
   logic [PC_W-1:0]    pc_s;
   logic [DIST_W-1:0]  dist_h;
   logic [DIST_W-1:0]  dist_s;
   logic [1:0]         verdict_c;
   logic               unused_c;

   // label is reserved for a future training path
   assign unused_c  = ^label;
   assign len_c     = (length > CAP) ? CAP : length;
   assign change_c  = (msg != msg_q) || (length != len_q);
   assign restart_c = change_c || start_q;

   // Input snapshot for change detection; tracks inputs even during reset
   always_ff @(posedge clk) begin
      msg_q <= msg;
      len_q <= length;
   end

   // Trigram of the three leading chars of the shifting message window
   always_comb begin
      tri_c = rotl(rotl(BASE_HV, 32'(msg_w[MSG_W-1  -: 8])), 2)
            ^ rotl(rotl(BASE_HV, 32'(msg_w[MSG_W-9  -: 8])), 1)
            ^ rotl(BASE_HV, 32'(msg_w[MSG_W-17 -: 8]));
   end

   // Majority threshold: strict 2*cnt > N, so an exact half gives 0
   always_comb begin
      query_c = '0;
      for (int j = 0; j < int'(D); j++) begin
         query_c[j] = ({1'b0, cnt[j], 1'b0} > {2'b00, n_w});
      end
   end

   // Class decision from the accumulated distances
   always_comb begin
      verdict_c = LBL_NONE;
      if (n_ok) begin
         if (dist_h < dist_s) begin
            verdict_c = LBL_HAM;
         end else if (dist_s < dist_h) begin
            verdict_c = LBL_SPAM;
         end else begin
`ifdef HDC_TIE_HAM_EN
            verdict_c = LBL_HAM;
`else
            verdict_c = LBL_NONE;
`endif
         end
      end
   end

   hdc_popcount #(.W(CHUNK)) u_pc_h (.vec(diff_h[CHUNK-1:0]), .count_c(pc_h));
   hdc_popcount #(.W(CHUNK)) u_pc_s (.vec(diff_s[CHUNK-1:0]), .count_c(pc_s));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; any input change or the post-reset start forces LOAD
   always_comb begin
      state_d = state_q;
      if (restart_c) begin
         state_d = S_LOAD;
      end else begin
         case (state_q)
            S_IDLE:    state_d = S_IDLE;
            S_LOAD:    state_d = (len_c >= 8'd3) ? S_ENCODE : S_DONE;
            S_ENCODE:  if (idx == len_w - 8'd1) state_d = S_THRESH;
            S_THRESH:  state_d = S_COMPARE;
            S_COMPARE: if (idx == LAST_CHUNK) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // Datapath: capture, bundle, threshold, accumulate distances, publish result
   always_ff @(posedge clk) begin
      if (reset) begin
         start_q <= 1'b1;
         result  <= LBL_NONE;
         dist_h  <= '0;
         dist_s  <= '0;
         idx     <= '0;
         n_ok    <= 1'b0;
         n_w     <= '0;
         len_w   <= '0;
         for (int j = 0; j < int'(D); j++) begin
            cnt[j] <= '0;
         end
      end else begin
         start_q <= 1'b0;
         case (state_q)
            S_LOAD: begin
               msg_w  <= msg;
               len_w  <= len_c;
               n_w    <= len_c - 8'd2;
               n_ok   <= (len_c >= 8'd3);
               idx    <= 8'd2;
               dist_h <= '0;
               dist_s <= '0;
               result <= LBL_NONE;
               for (int j = 0; j < int'(D); j++) begin
                  cnt[j] <= '0;
               end
            end
            S_ENCODE: begin
               for (int j = 0; j < int'(D); j++) begin
                  if (tri_c[j] && (cnt[j] != '1)) begin
                     cnt[j] <= cnt[j] + CNT_W'(1);
                  end
               end
               msg_w <= msg_w << 8;
               idx   <= idx + 8'd1;
            end
            S_THRESH: begin
               diff_h <= query_c ^ HAM_CLASS;
               diff_s <= query_c ^ SPAM_CLASS;
               idx    <= '0;
            end
            S_COMPARE: begin
               dist_h <= dist_h + DIST_W'(pc_h);
               dist_s <= dist_s + DIST_W'(pc_s);
               diff_h <= diff_h >> CHUNK;
               diff_s <= diff_s >> CHUNK;
               idx    <= idx + 8'd1;
            end
            S_DONE: begin
               if (!restart_c) begin
                  result <= verdict_c;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hdc_main.sv
// tb_hdc_main: scoreboard bench for hdc_main. Two instances share the inputs:
// one with forced class vectors ('a' query as ham, 'z' query as spam) and one
// with identical class vectors so every N>0 message is a distance tie.
module tb_hdc_main;
   import hdc_pkg::*;

   localparam int unsigned MSG_W = 8 * MSG_CHARS;

   localparam logic [D-1:0] Q_A = rotl(rotl(BASE_HV, 32'h61), 2)
                                ^ rotl(rotl(BASE_HV, 32'h61), 1)
                                ^ rotl(BASE_HV, 32'h61);
   localparam logic [D-1:0] Q_Z = rotl(rotl(BASE_HV, 32'h7a), 2)
                                ^ rotl(rotl(BASE_HV, 32'h7a), 1)
                                ^ rotl(BASE_HV, 32'h7a);
`ifdef HDC_TIE_HAM_EN
   localparam logic [1:0] TIE_RES = 2'b00;
`else
   localparam logic [1:0] TIE_RES = 2'b11;
`endif

   typedef struct {
      string      name;
      logic [1:0] exp_m;
      logic [1:0] exp_t;
   } sb_item_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [MSG_W-1:0] msg;
   logic [7:0]       length;
   logic [1:0]       label;
   logic [1:0]       result;
   logic [1:0]       result_t;

   sb_item_t sb_q[$];
   int       n_tests = 0;
   int       n_fail  = 0;
   event     sample_ev;

   hdc_main #(.HAM_CLASS(Q_A), .SPAM_CLASS(Q_Z)) dut (
      .clk(clk), .reset(reset), .msg(msg), .length(length), .label(label), .result(result)
   );

   hdc_main #(.HAM_CLASS(Q_A), .SPAM_CLASS(Q_A)) dut_t (
      .clk(clk), .reset(reset), .msg(msg), .length(length), .label(label), .result(result_t)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: result=%b expected=%b", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int chr(input logic [MSG_W-1:0] m, input int i);
      logic [7:0] c;
      c = m[8*(int'(MSG_CHARS)-i)-1 -: 8];
      return int'(c);
   endfunction

   // Bit-level reference: bit j of rotl(BASE_HV, s) is BASE_HV[(j - s) mod D]
   function automatic logic [1:0] model(input logic [MSG_W-1:0] m, input int len,
                                        input logic [D-1:0] hv_h, input logic [D-1:0] hv_s);
      int   l, n, dh, ds, c0, c1, c2, dd;
      int   cnt [D];
      logic b, q;
      dd = int'(D);
      l  = (len > int'(MSG_CHARS)) ? int'(MSG_CHARS) : len;
      n  = l - 2;
      if (n <= 0) return 2'b11;
      for (int j = 0; j < dd; j++) cnt[j] = 0;
      for (int i = 2; i < l; i++) begin
         c0 = chr(m, i - 2);
         c1 = chr(m, i - 1);
         c2 = chr(m, i);
         for (int j = 0; j < dd; j++) begin
            b = BASE_HV[(j - c0 - 2 + 2*dd) % dd] ^ BASE_HV[(j - c1 - 1 + 2*dd) % dd]
              ^ BASE_HV[(j - c2 + 2*dd) % dd];
            if (b && cnt[j] < 255) cnt[j]++;
         end
      end
      dh = 0;
      ds = 0;
      for (int j = 0; j < dd; j++) begin
         q = (2 * cnt[j] > n);
         if (q != hv_h[j]) dh++;
         if (q != hv_s[j]) ds++;
      end
      if (dh < ds) return 2'b00;
      if (ds < dh) return 2'b01;
      return TIE_RES;
   endfunction

   function automatic logic [MSG_W-1:0] fill(input logic [7:0] c);
      logic [MSG_W-1:0] m;
      for (int i = 0; i < int'(MSG_CHARS); i++) m[8*i +: 8] = c;
      return m;
   endfunction

   function automatic logic [MSG_W-1:0] rand_msg();
      logic [MSG_W-1:0] m;
      for (int i = 0; i < int'(MSG_CHARS); i++) m[8*i +: 8] = 8'($urandom_range(0, 255));
      return m;
   endfunction

   function automatic sb_item_t expect_item(input string name, input logic [MSG_W-1:0] m,
                                            input logic [7:0] len);
      sb_item_t it;
      it.name  = name;
      it.exp_m = model(m, int'(len), Q_A, Q_Z);
      it.exp_t = model(m, int'(len), Q_A, Q_A);
      return it;
   endfunction

   // Queue expectation, drive inputs, let the classification settle, then hand to the monitor
   task automatic run(input string name, input logic [MSG_W-1:0] m, input logic [7:0] len,
                      input int cycles);
      sb_q.push_back(expect_item(name, m, len));
      msg    = m;
      length = len;
      label  = label + 2'd1;
      tick(cycles);
      -> sample_ev;
   endtask

   // Monitor: pops one expectation per sample point and compares both instances
   initial begin : monitor
      sb_item_t it;
      forever begin
         @(sample_ev);
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: sample with no queued expectation");
         end else begin
            it = sb_q.pop_front();
            check({it.name, "_main"}, result, it.exp_m);
            check({it.name, "_tie"}, result_t, it.exp_t);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [MSG_W-1:0] r, m1, m2;
      logic [7:0]       len;
      reset  = 1'b1;
      msg    = fill(8'h61);
      length = 8'd200;
      label  = 2'd0;
      tick(3);
      check("reset_hold_main", result, 2'b11);
      check("reset_hold_tie", result_t, 2'b11);

      // First classification starts by itself after reset release
      sb_q.push_back(expect_item("post_reset_a200", fill(8'h61), 8'd200));
      reset = 1'b0;
      tick(1);
      check("post_reset_c1", result, 2'b11);
      tick(4);
      check("post_reset_c5", result, 2'b11);
      tick(45);
      check("post_reset_c50", result, 2'b11);
      tick(150);
      check("post_reset_c200", result_t, 2'b11);
      tick(40);
      -> sample_ev;

      run("z200", fill(8'h7a), 8'd200, 240);
      run("z255", fill(8'h7a), 8'd255, 240);
      run("len0", fill(8'h7a), 8'd0, 4);
      run("a200", fill(8'h61), 8'd200, 240);
      run("len1", fill(8'h61), 8'd1, 4);
      run("z200b", fill(8'h7a), 8'd200, 240);
      run("len2", fill(8'h7a), 8'd2, 4);
      run("a3", fill(8'h61), 8'd3, 240);

      r = rand_msg();
      run("r200", r, 8'd200, 240);
      run("r255", r, 8'd255, 240);

      for (int k = 0; k < 10; k++) begin
         len = (k == 0) ? 8'd3 : (k == 1) ? 8'd200 : 8'($urandom_range(3, 200));
         run($sformatf("rand%0d_len%0d", k, len), rand_msg(), len, 240);
      end

      // Abort during ENCODE; only the replacement message may be reported
      m1     = rand_msg();
      m2     = rand_msg();
      msg    = m1;
      length = 8'd200;
      tick(30);
      check("restart_in_encode", result, 2'b11);
      sb_q.push_back(expect_item("restart_new_msg", m2, 8'd150));
      msg    = m2;
      length = 8'd150;
      tick(5);
      check("restart_c5", result, 2'b11);
      tick(100);
      check("restart_c105", result, 2'b11);
      tick(135);
      -> sample_ev;

      tick(2);
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d expectations left, 0 required", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hdc_main.md
# hdc_main

Hyperdimensional-computing (HDC) text classifier for ham/spam messages, top level of the FPGA-HDC datapath. It takes a fixed-width byte message and its valid length, encodes character trigrams into a binary hypervector, and bundles them by per-bit majority. The query is compared against two stored class hypervectors by Hamming distance, and the block reports ham, spam or inconclusive on `result`.

## Interface
- `D`, 1024: hypervector dimension in bits; must be a multiple of `CHUNK`.
- `CHUNK`, 64: bits popcounted per cycle during comparison.
- `MSG_CHARS`, 200: message capacity in bytes.
- `clk` in 1: the block's single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `msg` in 8*MSG_CHARS: message bytes. Char 0 is at `msg[8*MSG_CHARS-1 -: 8]`; char i is at `msg[8*(MSG_CHARS-i)-1 -: 8]`.
- `length` in 8: number of valid chars. Values above MSG_CHARS are clamped to MSG_CHARS.
- `label` in 2: ground-truth tag. Accepted and ignored; reserved for future training.
- `result` out 2: 2'b00 = ham, 2'b01 = spam, 2'b11 = inconclusive. 2'b10 is never driven.

## Operation
- Item vector for byte c: `rotl(BASE_HV, c)`. `BASE_HV` is a fixed D-bit pseudo-random constant.
- Trigram vector at position i (i ≥ 2): `rotl(item(c[i-2]),2) ^ rotl(item(c[i-1]),1) ^ item(c[i])`.
- N = clamped length − 2 trigrams. If N ≤ 0, go straight to DONE with `result` = 2'b11.
- Bundling:
  - D counters, each 8 bits, unsigned, saturating.
  - Each counter increments when its trigram bit is 1.
  - Query bit j = 1 iff 2*cnt[j] > N. An exact half gives 0.
- Comparison: dH = popcount(query ^ HAM_HV), dS = popcount(query ^ SPAM_HV). Accumulators are 11 bits wide (log2(D)+1).
- Decision: dH < dS → 2'b00. dS < dH → 2'b01. dH == dS → tie, resolved per Configuration.
- Input change detection: `msg` and `length` are registered every cycle. Any difference from the registered copy, in any state, aborts and restarts in LOAD on the next cycle.
- FSM states and transitions:
  - IDLE → LOAD when an input change is detected, or on the first cycle after reset.
  - LOAD: capture inputs, clear counters, i = 2.
  - ENCODE: one trigram per cycle; i increments; leave after i = clamped length − 1.
  - THRESH: form the query; 1 cycle.
  - COMPARE: D/CHUNK cycles.
  - DONE: update `result`; 1 cycle; → IDLE.

## Timing
- Reset: `result` = 2'b11, state = IDLE, counters cleared, distances 0. The first cycle after reset deassertion starts a classification of the present inputs.
- `result` = 2'b11 from the cycle after LOAD until the DONE update. It then holds until the next restart.
- Latency from input change to valid `result`: 1 (detect) + 1 (LOAD) + N + 1 + D/CHUNK + 1 cycles. With defaults and length 200, this is 218 cycles, within 1000.
- Reset asserted mid-operation wins over everything and returns to the reset values on the next edge.
- A restart and DONE in the same cycle: the restart wins and `result` stays 2'b11.

## Configuration
- `HDC_TIE_HAM_EN`
  - Defined: a tie (dH == dS, N > 0) yields 2'b00.
  - Undefined (default): a tie yields 2'b11.
- N ≤ 0 always yields 2'b11.

## Structure
- Package `hdc_pkg` holds:
  - `BASE_HV`, `HAM_HV`, `SPAM_HV` (D-bit constants);
  - the label encodings `LBL_HAM`, `LBL_SPAM`, `LBL_NONE`;
  - the FSM state enum;
  - the `rotl` function.
- One sub-module, `hdc_popcount`: a CHUNK-bit population count, instantiated twice (ham and spam).
- Everything else stays in `hdc_main`.

## Test plan
- Reset: hold `reset` 3 cycles → `result` = 2'b11. After release it stays 2'b11 through LOAD/ENCODE.
- Boundary lengths:
  - `length` = 0, 1 or 2 → `result` = 2'b11 within 4 cycles.
  - `length` = 255 → behaves identically to `length` = 200.
- Forced classes: the bench derives `HAM_HV` as the query of a message of 200 × 'a' (8'h61) and overrides the package constant. That message → 2'b00. A message of 200 × 'z' whose query equals `SPAM_HV` → 2'b01.
- Reference model: 10 random messages, lengths 3..200 → `result` matches a bit-exact software model after 1000 cycles. Label values are irrelevant.
- Tie: `HAM_HV` == `SPAM_HV` → 2'b11 without `HDC_TIE_HAM_EN`, 2'b00 with it.
- Mid-run restart: change `msg` during ENCODE → `result` stays 2'b11. The final value matches the model for the new message only.
